// File: rtl/gated_clk_en_ctrl.sv
// rtl/gated_clk_en_ctrl.sv - idle-detect enable controller driving gated_clk_cell module_en/local_en
module gated_clk_en_ctrl #(
    parameter int IDLE_CNT_W = 6,
    parameter int WAKE_DLY   = 2
) (
    input  logic                  clk_in,          // free-running ungated clock
    input  logic                  rst,             // synchronous, active-high
    input  logic                  cfg_auto_en,     // 0 forces the clock on
    input  logic [IDLE_CNT_W-1:0] cfg_idle_thresh, // idle cycles before gating, 0 disables
    input  logic                  unit_busy,       // activity from the gated unit
    input  logic                  wake_req,        // level request, held until wake_ack
    input  logic                  force_on,        // debug override
    output logic                  module_en,       // to gated_clk_cell.module_en
    output logic                  local_en,        // to gated_clk_cell.local_en
    output logic                  wake_ack,        // one-cycle pulse, clock settled
    output logic                  gated_st,        // high while gated
    output logic                  err_busy_gated   // sticky: busy seen while gated
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_GATED = 2'd1,
        ST_WAKE  = 2'd2
    } state_t;

    localparam logic [IDLE_CNT_W-1:0] CNT_ONE   = IDLE_CNT_W'(1);
    localparam logic [3:0]            WCNT_LAST = 4'(WAKE_DLY - 1);

    state_t                state;
    state_t                next_state;
    logic [IDLE_CNT_W-1:0] cnt;
    logic [3:0]            wcnt;

    logic thresh_zero;
    logic idle;
    logic thresh_hit;
    logic wake_cond;
    logic wake_done;

    assign thresh_zero = (cfg_idle_thresh == '0);
    assign idle        = !unit_busy && !wake_req && cfg_auto_en && !thresh_zero;
    // >= rather than == so a threshold lowered mid-count gates on the next idle cycle.
    // Only meaningful when idle, which already excludes a zero threshold.
    assign thresh_hit  = (cnt >= (cfg_idle_thresh - CNT_ONE));
    assign wake_cond   = wake_req || unit_busy || !cfg_auto_en || thresh_zero;
    assign wake_done   = (wcnt == WCNT_LAST);

    always_comb begin
        next_state = state;
        case (state)
            ST_RUN:   if (idle && thresh_hit) next_state = ST_GATED;
            ST_GATED: if (wake_cond)          next_state = ST_WAKE;
            ST_WAKE:  if (wake_done)          next_state = ST_RUN;
            default:                          next_state = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state          <= ST_RUN;
            cnt            <= '0;
            wcnt           <= '0;
            module_en      <= 1'b1;
            gated_st       <= 1'b0;
            wake_ack       <= 1'b0;
            local_en       <= 1'b0;
            err_busy_gated <= 1'b0;
        end else begin
            state     <= next_state;
            local_en  <= force_on;
            module_en <= (next_state != ST_GATED);
            gated_st  <= (next_state == ST_GATED);
            // Self-clearing term makes a held request pulse every other cycle.
            wake_ack  <= (state == ST_RUN) && (next_state == ST_RUN) && wake_req && !wake_ack;

            case (state)
                ST_RUN: begin
                    wcnt <= '0;
                    if (idle && !thresh_hit) cnt <= cnt + CNT_ONE;
                    else                     cnt <= '0;
                end
                ST_GATED: begin
                    cnt  <= '0;
                    wcnt <= '0;
                    if (unit_busy) err_busy_gated <= 1'b1;
                end
                ST_WAKE: begin
                    cnt <= '0;
                    if (wake_done) wcnt <= '0;
                    else           wcnt <= wcnt + 4'd1;
                end
                default: begin
                    cnt  <= '0;
                    wcnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gated_clk_en_ctrl.sv
// tb/tb_gated_clk_en_ctrl.sv - self-checking bench for gated_clk_en_ctrl
module tb_gated_clk_en_ctrl;

    localparam int IDLE_CNT_W = 6;
    localparam int WAKE_DLY   = 2;

    logic                  clk_in = 1'b0;
    logic                  rst = 1'b1;
    logic                  cfg_auto_en = 1'b1;
    logic [IDLE_CNT_W-1:0] cfg_idle_thresh = '0;
    logic                  unit_busy = 1'b0;
    logic                  wake_req = 1'b0;
    logic                  force_on = 1'b0;
    logic                  module_en, local_en, wake_ack, gated_st, err_busy_gated;

    int n_checks = 0;
    int n_fail   = 0;

    gated_clk_en_ctrl #(.IDLE_CNT_W(IDLE_CNT_W), .WAKE_DLY(WAKE_DLY)) dut (
        .clk_in(clk_in), .rst(rst), .cfg_auto_en(cfg_auto_en),
        .cfg_idle_thresh(cfg_idle_thresh), .unit_busy(unit_busy),
        .wake_req(wake_req), .force_on(force_on), .module_en(module_en),
        .local_en(local_en), .wake_ack(wake_ack), .gated_st(gated_st),
        .err_busy_gated(err_busy_gated)
    );

    always #5 clk_in = ~clk_in;

    // Behavioural model: mode plus a count of consecutive idle cycles and
    // the number of settle cycles still owed before running again.
    localparam int M_RUN = 0, M_GATED = 1, M_WAKE = 2;
    int m_mode = M_RUN;
    int m_idle_run = 0;
    int m_wake_left = 0;
    bit m_ack = 0, m_err = 0, m_local = 0;

    task automatic model_step();
        int  old_mode;
        bit  old_ack;
        bit  is_idle;
        old_mode = m_mode;
        old_ack  = m_ack;
        is_idle  = !unit_busy && !wake_req && cfg_auto_en && (cfg_idle_thresh != 0);
        if (rst) begin
            m_mode = M_RUN; m_idle_run = 0; m_wake_left = 0;
            m_ack = 0; m_err = 0; m_local = 0;
        end else begin
            m_local = force_on;
            case (m_mode)
                M_RUN: begin
                    if (is_idle) begin
                        m_idle_run++;
                        if (m_idle_run >= int'(cfg_idle_thresh)) begin
                            m_mode = M_GATED;
                            m_idle_run = 0;
                        end
                    end else begin
                        m_idle_run = 0;
                    end
                end
                M_GATED: begin
                    if (unit_busy) m_err = 1;
                    if (wake_req || unit_busy || !cfg_auto_en || cfg_idle_thresh == 0) begin
                        m_mode = M_WAKE;
                        m_wake_left = WAKE_DLY;
                    end
                end
                default: begin
                    m_wake_left--;
                    if (m_wake_left == 0) m_mode = M_RUN;
                end
            endcase
            m_ack = (old_mode == M_RUN) && (m_mode == M_RUN) && wake_req && !old_ack;
        end
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".module_en"}, module_en, m_mode != M_GATED);
        chk({tag, ".gated_st"}, gated_st, m_mode == M_GATED);
        chk({tag, ".wake_ack"}, wake_ack, m_ack);
        chk({tag, ".err_busy_gated"}, err_busy_gated, m_err);
        chk({tag, ".local_en"}, local_en, m_local);
    endtask

    // Inputs are held across the edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk_in);
        model_step();
        #1;
    endtask

    typedef struct {
        logic                  rst, auto_en, busy, wreq, force_on;
        logic [IDLE_CNT_W-1:0] thresh;
        logic                  e_men, e_gst, e_ack, e_err, e_len;
    } vec_t;

    vec_t vecs[16];

    initial begin
        //            rst auto busy wreq frc thr  men gst ack err len
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        // Gate after four idle edges, wake with a held request, ack cadence.
        for (int i = 0; i < 16; i++) begin
            rst = vecs[i].rst; cfg_auto_en = vecs[i].auto_en; unit_busy = vecs[i].busy;
            wake_req = vecs[i].wreq; force_on = vecs[i].force_on; cfg_idle_thresh = vecs[i].thresh;
            tick();
            chk($sformatf("vec%0d.module_en", i), module_en, vecs[i].e_men);
            chk($sformatf("vec%0d.gated_st", i), gated_st, vecs[i].e_gst);
            chk($sformatf("vec%0d.wake_ack", i), wake_ack, vecs[i].e_ack);
            chk($sformatf("vec%0d.err_busy_gated", i), err_busy_gated, vecs[i].e_err);
            chk($sformatf("vec%0d.local_en", i), local_en, vecs[i].e_len);
        end

        // Busy every third cycle with threshold 3 never reaches the gate.
        cfg_idle_thresh = 6'd3;
        for (int i = 0; i < 30; i++) begin
            unit_busy = (i % 3 == 0);
            tick();
            chk("busy3.gated_st", gated_st, 1'b0);
            chk_model("busy3");
        end
        unit_busy = 1'b0;

        // Busy while gated: wake and sticky error.
        cfg_idle_thresh = 6'd2;
        tick(); tick();
        chk("gate2.gated_st", gated_st, 1'b1);
        unit_busy = 1'b1; tick(); unit_busy = 1'b0;
        chk("busy_gated.module_en", module_en, 1'b1);
        chk("busy_gated.err", err_busy_gated, 1'b1);
        cfg_auto_en = 1'b0;
        for (int i = 0; i < 6; i++) begin tick(); chk_model("err_sticky"); end
        chk("err_sticky.err", err_busy_gated, 1'b1);
        cfg_auto_en = 1'b1;

        // Threshold lowered mid-count, then zero threshold wakes and stays running.
        cfg_idle_thresh = 6'd20;
        for (int i = 0; i < 10; i++) begin tick(); chk_model("cnt20"); end
        chk("cnt20.gated_st", gated_st, 1'b0);
        cfg_idle_thresh = 6'd2;
        tick();
        chk("lowered.gated_st", gated_st, 1'b1);
        cfg_idle_thresh = 6'd0;
        tick();
        chk("thr0.module_en", module_en, 1'b1);
        chk("thr0.gated_st", gated_st, 1'b0);
        for (int i = 0; i < 20; i++) begin tick(); chk_model("thr0_run"); end

        // Reset mid-WAKE with force_on high, then reset while gated with error set.
        cfg_idle_thresh = 6'd1;
        tick();
        chk("gate1.gated_st", gated_st, 1'b1);
        wake_req = 1'b1; tick(); tick(); wake_req = 1'b0;
        rst = 1'b1; force_on = 1'b1; tick();
        chk("rst_wake.module_en", module_en, 1'b1);
        chk_model("rst_wake");
        chk("rst_wake.local_en", local_en, 1'b0);
        rst = 1'b0; tick();
        chk("force1.local_en", local_en, 1'b1);
        force_on = 1'b0; tick();
        chk("force0.local_en", local_en, 1'b0);
        chk("regate.gated_st", gated_st, 1'b1);
        unit_busy = 1'b1; tick(); unit_busy = 1'b0;
        chk("err_again.err", err_busy_gated, 1'b1);
        cfg_auto_en = 1'b0; tick(); tick();
        cfg_auto_en = 1'b1; cfg_idle_thresh = 6'd1; tick();
        chk("gated_err.gated_st", gated_st, 1'b1);
        rst = 1'b1; tick();
        chk("rst_gated.err", err_busy_gated, 1'b0);
        chk("rst_gated.module_en", module_en, 1'b1);
        chk_model("rst_gated");
        rst = 1'b0;

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            cfg_auto_en = ($urandom_range(0, 15) != 0);
            unit_busy   = ($urandom_range(0, 7) == 0);
            wake_req    = ($urandom_range(0, 9) == 0);
            force_on    = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 31) == 0) cfg_idle_thresh = IDLE_CNT_W'($urandom_range(0, 6));
            tick();
            chk_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gated_clk_en_ctrl.md
# gated_clk_en_ctrl

Idle-detect enable controller that sits directly upstream of `gated_clk_cell` and drives its `module_en` and `local_en` inputs. It watches a functional unit's activity and gates the unit's clock after a programmable run of idle cycles. It re-opens the clock on a wake request through a req/ack handshake that guarantees a settle window before work resumes. It runs on the free-running, ungated clock.

## Interface

Parameters:
- `IDLE_CNT_W`, 6 — width of the idle-threshold config and the idle counter.
- `WAKE_DLY`, 2 — cycles `module_en` is held high in WAKE before RUN is entered; legal range is 1 to 15.

Ports:
- `clk_in` input 1 — free-running ungated clock.
- `rst` input 1 — reset, synchronous, active-high.
- `cfg_auto_en` input 1 — enables auto-gating; 0 forces the clock on.
- `cfg_idle_thresh` input IDLE_CNT_W — consecutive idle cycles before gating; 0 disables auto-gating.
- `unit_busy` input 1 — activity indication from the gated unit.
- `wake_req` input 1 — level request for the clock; held until `wake_ack`.
- `force_on` input 1 — debug override, forwarded to `local_en`.
- `module_en` output 1 — to `gated_clk_cell.module_en`.
- `local_en` output 1 — to `gated_clk_cell.local_en`.
- `wake_ack` output 1 — one-cycle pulse: clock is running and settled.
- `gated_st` output 1 — high while in GATED.
- `err_busy_gated` output 1 — sticky flag: `unit_busy` was seen while gated.

## Operation

- Define `idle` as `!unit_busy && !wake_req && cfg_auto_en && (cfg_idle_thresh != 0)`.
- The FSM has three states: RUN, GATED and WAKE. All outputs are registered.

**RUN** (`module_en`=1)
- The idle counter `cnt` increments on each `idle` cycle.
- Any non-idle cycle clears `cnt` to 0.
- If `idle` and `cnt >= cfg_idle_thresh-1`, go to GATED and clear `cnt`.
- The `>=` comparison makes a threshold lowered mid-count take effect on the next idle cycle.

**GATED** (`module_en`=0, `gated_st`=1)
- Go to WAKE if any of these holds: `wake_req`, `unit_busy`, `!cfg_auto_en`, or `cfg_idle_thresh==0`.
- `unit_busy` while in GATED also sets `err_busy_gated`, which stays set until `rst`.

**WAKE** (`module_en`=1)
- `wcnt` counts 0 to WAKE_DLY-1, then the FSM goes to RUN.
- WAKE is not abortable; dropping `wake_req` does not shorten it.

**wake_ack**
- Next-cycle value is `state==RUN && next_state==RUN && wake_req && !wake_ack`.
- The requester must drop `wake_req` in the cycle after it sees `wake_ack`.
- If the requester keeps `wake_req` high, `wake_ack` pulses every other cycle. This is defined behaviour, not an error.
- A held `wake_req` also blocks `idle`, so the unit never gates while a request is pending.

**Other outputs**
- `local_en` is `force_on` registered by one cycle and is independent of the FSM.

**Reset**
- On `rst`: state=RUN, `module_en`=1, `cnt`=0, `wcnt`=0, `wake_ack`=0, `gated_st`=0, `local_en`=0, `err_busy_gated`=0.
- `rst` asserted in any state, including mid-WAKE or GATED, returns to these values at the next edge.

## Timing

- Gating latency: with a threshold of T, after T consecutive idle cycles sampled at edges 1..T, `module_en` falls at edge T.
- Wake latency from GATED:
  - `wake_req` sampled high at edge 0 → `module_en`=1 after edge 0 (state WAKE).
  - RUN after edge WAKE_DLY.
  - `wake_ack`=1 after edge WAKE_DLY+1, provided `wake_req` is still high.
- Wake while already in RUN: `wake_req` rising at edge 0 gives `wake_ack` high after edge 0.
- Simultaneous events:
  - `unit_busy` or `wake_req` in the cycle that would reach threshold wins; the FSM stays in RUN and `cnt` is cleared.
  - `cfg_auto_en` dropping in the same cycle also prevents gating.
- `module_en` changes only at `clk_in` edges. The downstream latch absorbs phase alignment.

## Test plan

1. Reset, then `cfg_idle_thresh`=4, `cfg_auto_en`=1, `unit_busy`=0 → `module_en` falls after the 4th edge and `gated_st` rises the same cycle; neither `wake_ack` nor `err_busy_gated` pulses.
2. From GATED, `wake_req`=1 held, WAKE_DLY=2 → `module_en`=1 next cycle, RUN after 2 cycles, one `wake_ack` pulse one cycle later; `wake_req` dropped after the ack → no second pulse.
3. `cfg_idle_thresh`=3 with `unit_busy` pulsing on every 3rd cycle → the clock never gates and `cnt` never exceeds 2.
4. In GATED, assert `unit_busy` without `wake_req` → WAKE entered and `err_busy_gated`=1, remaining 1 until `rst`.
5. Lower the threshold from 20 to 2 while `cnt`=10 → gate on the next idle cycle. Separately, `cfg_idle_thresh`=0 in GATED → WAKE, and the FSM stays in RUN permanently.
6. Assert `rst` mid-WAKE (`wcnt`=1) and also while GATED with `err_busy_gated`=1 → next cycle all outputs hold reset values (`module_en`=1, all others 0); toggle `force_on` → `local_en` follows one cycle later.
